// File: rtl/perceptron_trainer.sv
// Sequencer that streams buffered samples to a perceptron, compares its
// output with the expected value, and pulses train until an epoch is clean.
module perceptron_trainer #(
   parameter int N          = 8,
   parameter int DEPTH      = 16,
   parameter int ADDR_W     = 4,
   parameter int LAT        = 2,
   parameter int MAX_EPOCHS = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W:0]   num_samples,
   input  logic [31:0]       learning_rate_in,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [N-1:0]      wr_x,
   input  logic [31:0]       wr_y,
   input  logic [31:0]       y,
   output logic [N-1:0]      x,
   output logic [31:0]       expected_y,
   output logic [31:0]       learning_rate,
   output logic              train,
   output logic              busy,
   output logic              done,
   output logic              converged,
   output logic [7:0]        epoch_count,
   output logic [ADDR_W:0]   err_count
);

   localparam int WC_W = (LAT > 1) ? $clog2(LAT) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_CHECK,
      S_UPDATE
   } state_t;

   state_t              r_state;
   logic [N+31:0]       r_mem [DEPTH];
   logic [ADDR_W-1:0]   r_idx;
   logic [ADDR_W:0]     r_num;
   logic [WC_W-1:0]     r_wcnt;
   logic [N-1:0]        r_x;
   logic [31:0]         r_exp;
   logic [31:0]         r_lr;
   logic                r_train;
   logic                r_busy;
   logic                r_done;
   logic                r_conv;
   logic [7:0]          r_epoch;
   logic [ADDR_W:0]     r_err;

   logic [N+31:0]       w_rd;
   logic                w_adv;
   logic                w_last;
   logic [7:0]          w_epoch_nx;

   assign w_rd       = r_mem[r_idx];
   assign w_adv      = ((r_state == S_CHECK) && (y == r_exp)) ||
                       (r_state == S_UPDATE);
   assign w_last     = ({1'b0, r_idx} == (r_num - (ADDR_W+1)'(1)));
   assign w_epoch_nx = r_epoch + 8'd1;

   // Sample buffer has no reset; contents survive a reset.
   always_ff @(posedge clk) begin
      if (wr_en && !r_busy)
         r_mem[wr_addr] <= {wr_x, wr_y};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_num   <= '0;
         r_wcnt  <= '0;
         r_x     <= '0;
         r_exp   <= '0;
         r_lr    <= '0;
         r_train <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_conv  <= 1'b0;
         r_epoch <= '0;
         r_err   <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_num   <= num_samples;
                  r_lr    <= learning_rate_in;
                  r_conv  <= 1'b0;
                  r_epoch <= '0;
                  r_err   <= '0;
                  r_idx   <= '0;
                  if (num_samples == '0) begin
                     r_done <= 1'b1;
                     r_conv <= 1'b1;
                  end else begin
                     r_done  <= 1'b0;
                     r_busy  <= 1'b1;
                     r_state <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               r_x     <= w_rd[N+31:32];
               r_exp   <= w_rd[31:0];
               r_wcnt  <= '0;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (r_wcnt == WC_W'(LAT-1))
                  r_state <= S_CHECK;
               else
                  r_wcnt <= r_wcnt + WC_W'(1);
            end
            S_CHECK: begin
               if (y != r_exp) begin
                  r_err   <= r_err + (ADDR_W+1)'(1);
                  r_train <= 1'b1;
                  r_state <= S_UPDATE;
               end
            end
            S_UPDATE: begin
               r_train <= 1'b0;
            end
            default: r_state <= S_IDLE;
         endcase

         // Next-sample / end-of-epoch decision shared by CHECK and UPDATE.
         if (w_adv) begin
            if (!w_last) begin
               r_idx   <= r_idx + ADDR_W'(1);
               r_state <= S_ISSUE;
            end else begin
               r_epoch <= w_epoch_nx;
               if (r_err == '0) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_conv  <= 1'b1;
                  r_state <= S_IDLE;
               end else if (w_epoch_nx == 8'(MAX_EPOCHS)) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_conv  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_idx   <= '0;
                  r_err   <= '0;
                  r_state <= S_ISSUE;
               end
            end
         end
      end
   end

   assign x             = r_x;
   assign expected_y    = r_exp;
   assign learning_rate = r_lr;
   assign train         = r_train;
   assign busy          = r_busy;
   assign done          = r_done;
   assign converged     = r_conv;
   assign epoch_count   = r_epoch;
   assign err_count     = r_err;

endmodule

// File: tb/tb_perceptron_trainer.sv
// Directed bench for perceptron_trainer with a behavioural perceptron model.
module tb_perceptron_trainer;

   localparam int N = 8;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [AW:0]   num_samples = '0;
   logic [31:0]   lr_in = '0;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [N-1:0]  wr_x = '0;
   logic [31:0]   wr_y = '0;
   logic [31:0]   y;
   logic [N-1:0]  x;
   logic [31:0]   expected_y;
   logic [31:0]   learning_rate;
   logic          train, busy, done, converged;
   logic [7:0]    epoch_count;
   logic [AW:0]   err_count;

   int checks = 0;
   int errors = 0;

   int          mode = 0;
   int          base = 0;
   int          n_train = 0;
   logic [N-1:0] tr_x = '0;
   logic [7:0]  tr_ep = '0;

   logic [N-1:0] tx [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
   logic [31:0]  ty [4] = '{32'h0000_0101, 32'hFFFF_0002,
                            32'h8000_0003, 32'h1234_5678};

   always #5 clk = ~clk;

   // mode 0: always match; 1: miss sample 1 until trained; 2: always miss
   assign y = (mode == 2) ? ~expected_y :
              ((mode == 1) && (x == tx[1]) && (n_train == base)) ?
              (expected_y ^ 32'h1) : expected_y;

   always @(negedge clk) begin
      if (train) begin
         n_train <= n_train + 1;
         tr_x    <= x;
         tr_ep   <= epoch_count;
      end
   end

   perceptron_trainer #(
      .N(N), .DEPTH(16), .ADDR_W(AW), .LAT(2), .MAX_EPOCHS(3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .num_samples(num_samples),
      .learning_rate_in(lr_in),
      .wr_en(wr_en),
      .wr_addr(wr_addr),
      .wr_x(wr_x),
      .wr_y(wr_y),
      .y(y),
      .x(x),
      .expected_y(expected_y),
      .learning_rate(learning_rate),
      .train(train),
      .busy(busy),
      .done(done),
      .converged(converged),
      .epoch_count(epoch_count),
      .err_count(err_count)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wr(input int a, input logic [N-1:0] dx,
                     input logic [31:0] dy);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = AW'(a); wr_x = dx; wr_y = dy;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic go(input int n, input logic [31:0] lr);
      @(negedge clk);
      num_samples = (AW+1)'(n); lr_in = lr; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input int c0, output int cyc);
      cyc = c0;
      while (!done && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      chk("done_timeout", {63'd0, done}, 64'd1);
   endtask

   int cyc;

   initial begin
      #12;
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_x", {56'd0, x}, 64'd0);
      chk("rst_epoch", {56'd0, epoch_count}, 64'd0);
      rst = 1'b1;
      for (int i = 0; i < 4; i++) wr(i, tx[i], ty[i]);

      // zero samples
      go(0, 32'h1);
      chk("z_busy", {63'd0, busy}, 64'd0);
      chk("z_done", {63'd0, done}, 64'd1);
      chk("z_conv", {63'd0, converged}, 64'd1);
      chk("z_epoch", {56'd0, epoch_count}, 64'd0);
      chk("z_train", 64'(n_train), 64'd0);

      // clean first pass over 4 samples
      mode = 0; base = n_train;
      go(4, 32'h0000_8000);
      chk("c_busy", {63'd0, busy}, 64'd1);
      chk("c_done_clr", {63'd0, done}, 64'd0);
      chk("c_lr", {32'd0, learning_rate}, 64'h8000);
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         if ((c % 4) == 1) begin
            chk("c_x", {56'd0, x}, {56'd0, tx[(c-1)/4]});
            chk("c_ey", {32'd0, expected_y}, {32'd0, ty[(c-1)/4]});
         end
         if (c == 15) chk("c_done_early", {63'd0, done}, 64'd0);
      end
      chk("c_done", {63'd0, done}, 64'd1);
      chk("c_busy_end", {63'd0, busy}, 64'd0);
      chk("c_conv", {63'd0, converged}, 64'd1);
      chk("c_epoch", {56'd0, epoch_count}, 64'd1);
      chk("c_err", {59'd0, err_count}, 64'd0);
      chk("c_train", 64'(n_train - base), 64'd0);

      // learning run: sample 1 misses once
      mode = 1; base = n_train;
      go(2, 32'h1);
      wait_done(0, cyc);
      chk("l_cycles", 64'(cyc), 64'd17);
      chk("l_train", 64'(n_train - base), 64'd1);
      chk("l_train_x", {56'd0, tr_x}, {56'd0, tx[1]});
      chk("l_train_ep", {56'd0, tr_ep}, 64'd0);
      chk("l_conv", {63'd0, converged}, 64'd1);
      chk("l_epoch", {56'd0, epoch_count}, 64'd2);

      // never converges, limit 3 epochs
      mode = 2; base = n_train;
      go(2, 32'h1);
      wait_done(0, cyc);
      chk("n_cycles", 64'(cyc), 64'd30);
      chk("n_train", 64'(n_train - base), 64'd6);
      chk("n_conv", {63'd0, converged}, 64'd0);
      chk("n_epoch", {56'd0, epoch_count}, 64'd3);
      chk("n_err", {59'd0, err_count}, 64'd2);

      // busy guards
      mode = 0; base = n_train;
      go(4, 32'h2);
      @(negedge clk);
      start = 1'b1; wr_en = 1'b1; wr_addr = '0;
      wr_x = 8'h5A; wr_y = 32'hDEAD_BEEF;
      @(negedge clk);
      start = 1'b0; wr_en = 1'b0;
      wait_done(2, cyc);
      chk("g_cycles", 64'(cyc), 64'd16);
      chk("g_conv", {63'd0, converged}, 64'd1);
      chk("g_lr", {32'd0, learning_rate}, 64'h2);
      go(1, 32'h2);
      @(negedge clk);
      chk("g_mem0_x", {56'd0, x}, {56'd0, tx[0]});
      chk("g_mem0_y", {32'd0, expected_y}, {32'd0, ty[0]});
      wait_done(1, cyc);
      chk("g1_cycles", 64'(cyc), 64'd4);
      wr(0, 8'h5A, 32'hDEAD_BEEF);
      go(1, 32'h2);
      @(negedge clk);
      chk("g_new_x", {56'd0, x}, 64'h5A);
      chk("g_new_y", {32'd0, expected_y}, 64'hDEAD_BEEF);
      wait_done(1, cyc);
      wr(0, tx[0], ty[0]);

      // reset during UPDATE
      mode = 2; base = n_train;
      go(2, 32'h3);
      cyc = 0;
      while (!train && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      chk("r_saw_train", {63'd0, train}, 64'd1);
      rst = 1'b0;
      #1;
      chk("r_train", {63'd0, train}, 64'd0);
      chk("r_busy", {63'd0, busy}, 64'd0);
      chk("r_done", {63'd0, done}, 64'd0);
      chk("r_epoch", {56'd0, epoch_count}, 64'd0);
      chk("r_lr", {32'd0, learning_rate}, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      mode = 0; base = n_train;
      go(4, 32'h4);
      wait_done(0, cyc);
      chk("r2_cycles", 64'(cyc), 64'd16);
      chk("r2_conv", {63'd0, converged}, 64'd1);
      chk("r2_train", 64'(n_train - base), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
